ecc_sram_bank: RTL and testbench
================================

# ecc_sram_bank

SECDED-protected single-bank scratchpad that sits directly downstream of the AXI-to-memory converter and consumes its req/we/addr/be/wdata port, returning read data one cycle after each request. It stores 32-bit data as 39-bit extended-Hamming codewords in an internal 1R1W array. Partial writes are read-modify-write operations through a one-entry pending-write register with full forwarding, so the upstream port never stalls. Single-bit errors are corrected and counted; double-bit errors are flagged.

## Interface
- ADDR_WIDTH, 64, byte-address width; matches the converter's address port.
- DATA_WIDTH, 32, data width. 32 is the only legal value; any other value is an elaboration error.
- NUM_WORDS, 4096, number of 32-bit words. Must be ≥ 2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; **asynchronous, active-high**.
- req_i  in  1  request valid; always accepted (no grant).
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  byte address; word index = addr_i[ADDR_WIDTH-1:2]; addr_i[1:0] ignored.
- be_i  in  4  byte enables for writes; ignored for reads.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data.
- init_done_o  out  1  1 once the zero-initialisation sweep is complete.
- ecc_single_o  out  1  one-cycle pulse: corrected single-bit error.
- ecc_double_o  out  1  one-cycle pulse: uncorrectable error.
- oob_o  out  1  one-cycle pulse: request word index ≥ NUM_WORDS.
- err_addr_o  out  ADDR_WIDTH  byte address of the most recent ECC event (single or double).
- ecc_single_cnt_o  out  16  saturating count of corrected errors.

## Operation
- **Codeword layout:**
  - Positions 1..38 form a Hamming code; check bits occupy positions 1, 2, 4, 8, 16 and 32.
  - Data bits 0..31 fill the remaining positions in ascending order.
  - Bit 0 is overall parity over positions 1..38.
- **Decode:**
  - syndrome = recomputed check bits XOR stored check bits; P = overall parity over all 39 bits.
  - syndrome = 0 and P = 0: clean.
  - P = 1: single-bit error. Flip the bit at position syndrome (syndrome 0 means bit 0).
  - syndrome ≠ 0 and P = 0: double error. Data is passed through uncorrected.
- **FSM:**
  - INIT, entered on reset: writes encode(0) to word counter k = 0..NUM_WORDS-1, one word per cycle. Requests are ignored: no write, rdata_o unchanged, no pulses.
  - INIT → RUN after k = NUM_WORDS-1 is written.
  - RUN: normal operation.
- **Reads:** an in-range read at cycle t reads the array at t. At t+1:
  - rdata_o = decoded data.
  - ecc pulses fire as applicable.
  - err_addr_o is updated on any ECC event.
- **Writes (all go through the pending register):**
  - An in-range write at t reads the old word at t and decodes/corrects it.
  - merged = per-byte be_i ? wdata_i : old_data. This is captured with its word index in the pending register.
  - At t+1 the pending register writes encode(merged) to the array.
  - ECC events on the old word pulse at t+1, exactly as for a read.
  - A double error merges into the uncorrected data and still writes.
  - be_i = 0 writes the corrected old word back, which scrubs it.
- **Forwarding:** if the word read at t (by a read or a write's old-word fetch) matches the pending register committing at t, the pending merged data is used instead of the array. No ECC event is generated in that case.
- **Out-of-bounds requests:**
  - Writes are dropped.
  - Reads return 0 at t+1.
  - oob_o pulses at t+1. No array access occurs.
- **rdata_o** holds its value between read responses. A write response leaves it unchanged.
- **ecc_single_cnt_o** saturates at 0xFFFF.

## Timing
- Read latency is exactly 1 cycle, matching the converter's fixed-latency expectation. Back-to-back requests are accepted every cycle.
- Reset values:
  - rdata_o = 0, init_done_o = 0, all pulses = 0, err_addr_o = 0, ecc_single_cnt_o = 0.
  - The pending register is invalid.
  - The array contents are not reset; they are overwritten by INIT.
- init_done_o rises at the end of the NUM_WORDS-th clock edge after rst_i deasserts.
- Reset asserted mid-operation: the pending write is discarded (never committed), and INIT restarts from k = 0.
- When a single-bit and a double-bit event coincide in one cycle, only one access is decoded, so only one pulse fires.
- The counter increments in the same cycle as ecc_single_o.

## Test plan
- Reset → init_done_o rises after exactly NUM_WORDS cycles. A read of word 5 afterwards returns 0x00000000, with no ecc pulses.
- Write 0xDEADBEEF, be=0xF, to address 0x10, then immediately read 0x10 in the next cycle → rdata_o = 0xDEADBEEF one cycle later (forwarding path).
- Write 0x11223344 be=0xF to addr 0x20, then write 0xAABBCCDD be=0x5 to 0x20 back-to-back, then read 0x20 → 0x11BB33DD.
- Force a single data-bit flip (bit 7) in the stored word at 0x30 holding 0x000000FF; read 0x30 → rdata_o = 0x000000FF, ecc_single_o pulse, count = 1, err_addr_o = 0x30.
- Force two flipped bits in the word at 0x40; read 0x40 → ecc_double_o pulse, ecc_single_cnt_o unchanged, err_addr_o = 0x40.
- Read addr = NUM_WORDS*4 → rdata_o = 0 and an oob_o pulse. Assert rst_i during a pending write to 0x50 → after re-init, a read of 0x50 returns 0.

Source files
------------

// File: rtl/ecc_sram_bank.sv
// ============================================================================
// Module  : ecc_sram_bank
// Brief   : SECDED (39,32) single-bank scratchpad with RMW pending-write path
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_sram_bank #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  init_done_o,
    output logic                  ecc_single_o,
    output logic                  ecc_double_o,
    output logic                  oob_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [15:0]           ecc_single_cnt_o
);

    localparam int                    c_IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX  = c_IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-3:0] c_NUM_WORDS = (ADDR_WIDTH-2)'(NUM_WORDS);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("ecc_sram_bank: DATA_WIDTH must be 32");
        end
        if (NUM_WORDS < 2) begin : g_bad_num_words
            $error("ecc_sram_bank: NUM_WORDS must be >= 2");
        end
    endgenerate

    // Position p of the codeword is bit p; powers of two hold check bits, bit 0 overall parity.
    function automatic logic [38:0] f_encode(input logic [31:0] d);
        logic [38:0] cw;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            logic par;
            par = 1'b0;
            for (int p = 1; p < 39; p++) begin
                if (p[i]) par = par ^ cw[p];
            end
            cw[1 << i] = par;
        end
        cw[0] = ^cw[38:1];
        return cw;
    endfunction

    function automatic logic [5:0] f_syndrome(input logic [38:0] cw);
        logic [5:0] syn;
        syn = '0;
        for (int p = 1; p < 39; p++) begin
            if (cw[p]) syn = syn ^ p[5:0];
        end
        return syn;
    endfunction

    function automatic logic [31:0] f_extract(input logic [38:0] cw);
        logic [31:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = cw[p];
                k++;
            end
        end
        return d;
    endfunction

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDX_W-1:0]  r_init_cnt;
    logic [c_IDX_W-1:0]  w_init_cnt_nxt;

    logic [38:0]         r_mem [NUM_WORDS];
    logic                w_mem_we;
    logic [c_IDX_W-1:0]  w_mem_addr;
    logic [38:0]         w_mem_wdata;

    logic                r_pend_valid;
    logic [c_IDX_W-1:0]  r_pend_idx;
    logic [31:0]         r_pend_data;

    logic [31:0]         r_rdata;
    logic                r_single;
    logic                r_double;
    logic                r_oob;
    logic [ADDR_WIDTH-1:0] r_err_addr;
    logic [15:0]         r_cnt;

    logic [ADDR_WIDTH-3:0] w_word;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_in_range;
    logic                w_active;
    logic                w_fwd;
    logic [38:0]         w_rd_cw;
    logic [38:0]         w_corr_cw;
    logic [5:0]          w_syn;
    logic                w_par;
    logic [31:0]         w_old_data;
    logic [31:0]         w_merged;
    logic                w_single;
    logic                w_double;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_mem_we       = r_pend_valid;
        w_mem_addr     = r_pend_idx;
        w_mem_wdata    = f_encode(r_pend_data);
        if (r_state == ST_INIT) begin
            w_mem_we       = 1'b1;
            w_mem_addr     = r_init_cnt;
            w_mem_wdata    = f_encode(32'h0);
            w_init_cnt_nxt = r_init_cnt + 1'b1;
            if (r_init_cnt == c_LAST_IDX) begin
                w_state_nxt    = ST_RUN;
                w_init_cnt_nxt = '0;
            end
        end
    end

    // Storage is deliberately unreset; the INIT sweep establishes valid codewords.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end

    always_comb begin
        w_word     = addr_i[ADDR_WIDTH-1:2];
        w_idx      = w_word[c_IDX_W-1:0];
        w_in_range = (w_word < c_NUM_WORDS);
        w_active   = req_i && (r_state == ST_RUN);
        w_fwd      = r_pend_valid && (r_pend_idx == w_idx);
        w_rd_cw    = r_mem[w_idx];
        w_syn      = f_syndrome(w_rd_cw);
        w_par      = ^w_rd_cw;
        w_corr_cw  = w_rd_cw;
        if (w_par) begin
            if (w_syn == 6'd0)       w_corr_cw[0]     = ~w_rd_cw[0];
            else if (w_syn <= 6'd38) w_corr_cw[w_syn] = ~w_rd_cw[w_syn];
        end
        w_old_data = w_fwd ? r_pend_data : f_extract(w_corr_cw);
        w_single   = w_active && w_in_range && !w_fwd && w_par;
        w_double   = w_active && w_in_range && !w_fwd && !w_par && (w_syn != 6'd0);
        w_merged   = w_old_data;
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) w_merged[8*b +: 8] = wdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
            r_pend_data  <= '0;
            r_rdata      <= '0;
            r_single     <= 1'b0;
            r_double     <= 1'b0;
            r_oob        <= 1'b0;
            r_err_addr   <= '0;
            r_cnt        <= '0;
        end else begin
            r_pend_valid <= w_active && we_i && w_in_range;
            r_single     <= w_single;
            r_double     <= w_double;
            r_oob        <= w_active && !w_in_range;
            if (w_active && we_i && w_in_range) begin
                r_pend_idx  <= w_idx;
                r_pend_data <= w_merged;
            end
            if (w_active && !we_i) begin
                r_rdata <= w_in_range ? w_old_data : 32'h0;
            end
            if (w_single || w_double) begin
                r_err_addr <= addr_i;
            end
            if (w_single && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign rdata_o          = r_rdata;
    assign init_done_o      = (r_state == ST_RUN);
    assign ecc_single_o     = r_single;
    assign ecc_double_o     = r_double;
    assign oob_o            = r_oob;
    assign err_addr_o       = r_err_addr;
    assign ecc_single_cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ecc_sram_bank.sv
// ============================================================================
// Module  : tb_ecc_sram_bank
// Brief   : Scoreboard bench for ecc_sram_bank with directed vectors
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ecc_sram_bank;

    localparam int ADDR_WIDTH = 64;
    localparam int NUM_WORDS  = 64;

    logic                  clk;
    logic                  rst_i;
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [3:0]            be_i;
    logic [31:0]           wdata_i;
    logic [31:0]           rdata_o;
    logic                  init_done_o;
    logic                  ecc_single_o;
    logic                  ecc_double_o;
    logic                  oob_o;
    logic [ADDR_WIDTH-1:0] err_addr_o;
    logic [15:0]           ecc_single_cnt_o;

    ecc_sram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (32),
        .NUM_WORDS  (NUM_WORDS)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .we_i             (we_i),
        .addr_i           (addr_i),
        .be_i             (be_i),
        .wdata_i          (wdata_i),
        .rdata_o          (rdata_o),
        .init_done_o      (init_done_o),
        .ecc_single_o     (ecc_single_o),
        .ecc_double_o     (ecc_double_o),
        .oob_o            (oob_o),
        .err_addr_o       (err_addr_o),
        .ecc_single_cnt_o (ecc_single_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]           rdata;
        logic                  single;
        logic                  dbl;
        logic                  oob;
        logic [ADDR_WIDTH-1:0] ea;
        logic [15:0]           cnt;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]           m_rdata;
    logic [ADDR_WIDTH-1:0] m_ea;
    logic [15:0]           m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drives one request at the falling edge and records the hand-computed response.
    task automatic issue(input string nm, input logic we, input logic [ADDR_WIDTH-1:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input logic [31:0] erd,
                         input logic es, input logic ed, input logic eo);
        exp_t e;
        @(negedge clk);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = a;
        be_i    = be;
        wdata_i = wd;
        if (!we) m_rdata = erd;
        if (es) begin
            m_cnt = m_cnt + 16'd1;
            m_ea  = a;
        end
        if (ed) m_ea = a;
        e.rdata  = m_rdata;
        e.single = es;
        e.dbl    = ed;
        e.oob    = eo;
        e.ea     = m_ea;
        e.cnt    = m_cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_i = 1'b0;
            we_i  = 1'b0;
        end
    endtask

    task automatic flip_bit(input int word, input int pos);
        logic [38:0] cw;
        cw             = dut.r_mem[word];
        cw[pos]        = ~cw[pos];
        dut.r_mem[word] = cw;
    endtask

    task automatic wait_init(input bit inject);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (cycles < 4 * NUM_WORDS) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (inject && cycles == 10) begin
                // A write during INIT must be ignored entirely.
                req_i   = 1'b1;
                we_i    = 1'b1;
                addr_i  = 64'h8;
                be_i    = 4'hF;
                wdata_i = 32'h12345678;
                e.rdata = m_rdata; e.single = 1'b0; e.dbl = 1'b0; e.oob = 1'b0;
                e.ea    = m_ea;    e.cnt    = m_cnt;
                exp_q.push_back(e);
                name_q.push_back("init_ignored_wr");
            end
            if (cycles == 11) begin
                req_i = 1'b0;
                we_i  = 1'b0;
            end
            if (init_done_o) break;
        end
        chk("init_latency", 64'(cycles), 64'(NUM_WORDS));
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, ".rdata"},  64'(rdata_o),          64'(e.rdata));
                chk({nm, ".single"}, 64'(ecc_single_o),     64'(e.single));
                chk({nm, ".double"}, 64'(ecc_double_o),     64'(e.dbl));
                chk({nm, ".oob"},    64'(oob_o),            64'(e.oob));
                chk({nm, ".eaddr"},  64'(err_addr_o),       64'(e.ea));
                chk({nm, ".cnt"},    64'(ecc_single_cnt_o), 64'(e.cnt));
            end else if (init_done_o && !rst_i) begin
                chk("idle_pulses", 64'({ecc_single_o, ecc_double_o, oob_o}), 64'h0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_i   = 1'b1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        be_i    = '0;
        wdata_i = '0;
        m_rdata = '0;
        m_ea    = '0;
        m_cnt   = '0;

        repeat (3) @(negedge clk);
        chk("rst.rdata",     64'(rdata_o),          64'h0);
        chk("rst.init_done", 64'(init_done_o),      64'h0);
        chk("rst.pulses",    64'({ecc_single_o, ecc_double_o, oob_o}), 64'h0);
        chk("rst.eaddr",     64'(err_addr_o),       64'h0);
        chk("rst.cnt",       64'(ecc_single_cnt_o), 64'h0);
        rst_i = 1'b0;
        wait_init(1'b1);

        issue("rd_word5", 1'b0, 64'h14, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue("rd_word2", 1'b0, 64'h8,  4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        issue("wr_10",    1'b1, 64'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
        issue("rd_10_fw", 1'b0, 64'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);

        issue("wr_20a",   1'b1, 64'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, 1'b0, 1'b0);
        issue("wr_20b",   1'b1, 64'h20, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0, 1'b0);
        issue("rd_20",    1'b0, 64'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 1'b0, 1'b0);
        idle(2);
        issue("rd_20_arr", 1'b0, 64'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 1'b0, 1'b0);

        // Word 12 holds 0xFF; data bit 7 sits at codeword position 12.
        issue("wr_30",    1'b1, 64'h30, 4'hF, 32'h000000FF, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(2);
        flip_bit(12, 12);
        issue("rd_30_sec", 1'b0, 64'h30, 4'h0, 32'h0, 32'h000000FF, 1'b1, 1'b0, 1'b0);
        idle(1);
        issue("rd_30_sec2", 1'b0, 64'h30, 4'h0, 32'h0, 32'h000000FF, 1'b1, 1'b0, 1'b0);
        idle(1);
        issue("scrub_30", 1'b1, 64'h30, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(2);
        issue("rd_30_clean", 1'b0, 64'h30, 4'h0, 32'h0, 32'h000000FF, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Positions 3 and 5 are data bits 0 and 1 of the zeroed word 16.
        flip_bit(16, 3);
        flip_bit(16, 5);
        issue("rd_40_ded", 1'b0, 64'h40, 4'h0, 32'h0, 32'h00000003, 1'b0, 1'b1, 1'b0);
        idle(1);

        issue("rd_oob",   1'b0, 64'(NUM_WORDS * 4),     4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        issue("wr_oob",   1'b1, 64'(NUM_WORDS * 4 + 4), 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(2);
        issue("rd_04",    1'b0, 64'h4, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue("rd_last",  1'b0, 64'((NUM_WORDS - 1) * 4), 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        issue("wr_50",    1'b1, 64'h50, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        req_i = 1'b0;
        we_i  = 1'b0;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2.cnt",   64'(ecc_single_cnt_o), 64'h0);
        chk("rst2.eaddr", 64'(err_addr_o),       64'h0);
        m_rdata = '0;
        m_ea    = '0;
        m_cnt   = '0;
        rst_i   = 1'b0;
        wait_init(1'b0);
        issue("rd_50_reinit", 1'b0, 64'h50, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
